// File: rtl/argmax_feeder.sv
// argmax_feeder: requantizes a parallel row of signed accumulators and streams it lane by lane
// (index, value, enable) into the argmax cell, with a one-row holding buffer for back-to-back rows.
// Build option: define FEEDER_ROUND_EN for round-half-up before the shift (default truncates).
module argmax_feeder #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 16,
    parameter int CELL_AMOUNT = 4,
    parameter int SHIFT       = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CELL_AMOUNT*ACC_WIDTH-1:0] in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [DATA_WIDTH-1:0]            out_index,
    output logic [DATA_WIDTH-1:0]            out_value,
    output logic                             out_enable,
    output logic                             out_last
);
    localparam int QW = ACC_WIDTH + DATA_WIDTH + 2;
    localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(CELL_AMOUNT - 1);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t                           state_q, state_d;
    logic [CELL_AMOUNT*ACC_WIDTH-1:0] row_q, row_d, buf_q, buf_d;
    logic                             buf_full_q, buf_full_d;
    logic [DATA_WIDTH-1:0]            idx_q, idx_d, val_q, val_d;
    logic                             en_q, en_d, last_q, last_d;
    logic                             accept, start;
    // Working width is wide enough that the rounding add and the clamp compare never overflow.
    function automatic logic [DATA_WIDTH-1:0] requant(input logic [ACC_WIDTH-1:0] acc);
        logic signed [QW-1:0] q;
        q = {{(QW-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
`ifdef FEEDER_ROUND_EN
        q = q + ((QW'(1) << SHIFT) >> 1);
`endif
        q = q >>> SHIFT;
        if (q < 0) return '0;
        if (q > $signed({{(QW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}})) return '1;
        return q[DATA_WIDTH-1:0];
    endfunction
    function automatic logic [ACC_WIDTH-1:0] lane(input logic [CELL_AMOUNT*ACC_WIDTH-1:0] row,
                                                  input logic [DATA_WIDTH-1:0] i);
        return row[i*ACC_WIDTH +: ACC_WIDTH];
    endfunction
    assign in_ready   = !buf_full_q;
    assign accept     = in_valid && !buf_full_q;
    assign out_index  = idx_q;
    assign out_value  = val_q;
    assign out_enable = en_q;
    assign out_last   = last_q;
    // Next lane of the current row, or start a new row from the buffer or the input, or fall idle.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        idx_d      = '0;
        val_d      = '0;
        en_d       = 1'b0;
        last_d     = 1'b0;
        start      = 1'b0;
        if (state_q == STREAM && idx_q != LAST_IDX) begin
            idx_d  = idx_q + 1'b1;
            en_d   = 1'b1;
            last_d = idx_d == LAST_IDX;
            val_d  = requant(lane(row_q, idx_d));
            if (accept) begin
                buf_d      = in_data;
                buf_full_d = 1'b1;
            end
        end else if (state_q == STREAM && buf_full_q) begin
            row_d      = buf_q;
            buf_full_d = 1'b0;
            start      = 1'b1;
        end else if (accept) begin
            row_d = in_data;
            start = 1'b1;
        end else begin
            state_d = IDLE;
        end
        if (start) begin
            state_d = STREAM;
            en_d    = 1'b1;
            val_d   = requant(lane(row_d, '0));
        end
    end
    // State, row storage and registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            idx_q      <= '0;
            val_q      <= '0;
            en_q       <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
            en_q       <= en_d;
            last_q     <= last_d;
        end
    end
endmodule

// File: tb/tb_argmax_feeder.sv
// tb_argmax_feeder: token-queue model of the feeder plus directed rows with hand-computed values.
module tb_argmax_feeder;
    localparam int DW = 8, AW = 16, CA = 4, SH = 4;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
    logic [CA*AW-1:0] in_data = '0;
    logic in_ready, out_enable, out_last;
    logic [DW-1:0] out_index, out_value;
    int checks = 0, errors = 0;
    bit chk_en = 1'b0, m_acc, e_en;
    int e_idx, e_val, run = 0, max_run = 0;
    typedef struct {int idx; int val;} tok_t;
    tok_t mq[$];
    int cap_idx[$], cap_val[$];

    always #5 clk = ~clk;

    argmax_feeder #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CELL_AMOUNT(CA), .SHIFT(SH)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_index(out_index), .out_value(out_value), .out_enable(out_enable), .out_last(out_last)
    );

    function automatic int req_m(input logic [AW-1:0] a);
        longint v;
        v = longint'($signed(a));
`ifdef FEEDER_ROUND_EN
        if (SH > 0) v = v + (longint'(1) << (SH - 1));
`endif
        v = v >>> SH;
        return v < 0 ? 0 : (v > 2**DW - 1 ? 2**DW - 1 : int'(v));
    endfunction

    function automatic logic [CA*AW-1:0] mk(input logic [AW-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: every accepted row becomes CA tokens; one token is presented per cycle;
    // a row is accepted while at most one row's worth of tokens is still pending.
    initial forever begin
        @(posedge clk);
        if (reset) mq.delete();
        else begin
            m_acc = in_valid && mq.size() <= CA;
            if (mq.size() > 0) void'(mq.pop_front());
            if (m_acc) for (int i = 0; i < CA; i++) mq.push_back('{i, req_m(in_data[i*AW +: AW])});
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            e_en  = mq.size() > 0;
            e_idx = e_en ? mq[0].idx : 0;
            e_val = e_en ? mq[0].val : 0;
            check("enable", out_enable, e_en);
            check("index", out_index, e_idx);
            check("value", out_value, e_val);
            check("last", out_last, e_en && e_idx == CA - 1);
            check("ready", in_ready, mq.size() <= CA);
            if (out_enable) begin
                cap_idx.push_back(int'(out_index));
                cap_val.push_back(int'(out_value));
            end
            run = out_enable ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clear();
        cap_idx.delete();
        cap_val.delete();
        max_run = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [CA*AW-1:0] row);
        bit got;
        got = 1'b0;
        in_data  = row;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            got = in_ready;
            @(negedge clk);
            #1;
        end
        check("accept_timeout", got, 1);
    endtask

    initial begin
        int exp1[4] = '{16, 255, 0, 255};
        int best, bi;
        bit fin, found;
        logic [CA*AW-1:0] rows[3];
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset_ready", in_ready, 1);
        check("reset_enable", out_enable, 0);
        check("reset_index", out_index, 0);
        check("reset_last", out_last, 0);
        // single row
        clear();
        send(mk(16'h0100, 16'h0FF0, 16'hFFFB, 16'h7FFF));
        idle(6);
        check("t1_count", cap_val.size(), 4);
        for (int i = 0; i < cap_val.size() && i < 4; i++) begin
            check("t1_idx", cap_idx[i], i);
            check("t1_val", cap_val[i], exp1[i]);
        end
        check("t1_run", max_run, 4);
        check("t1_ready_after", in_ready, 1);
        // back-to-back: B offered the cycle after A, C queued behind
        clear();
        send(mk(16'h0010, 16'h0020, 16'h0030, 16'h0040));
        send(mk(16'h0050, 16'h0060, 16'h0070, 16'h0080));
        send(mk(16'h0090, 16'h00A0, 16'h00B0, 16'h00C0));
        idle(16);
        check("t2_count", cap_val.size(), 12);
        check("t2_run", max_run, 12);
        for (int i = 0; i < cap_val.size(); i++) begin
            check("t2_idx", cap_idx[i], i % 4);
            check("t2_val", cap_val[i], i + 1);
        end
        // backpressure: in_valid held high across three rows
        clear();
        rows[0] = mk(16'h1000, 16'hF000, 16'h0011, 16'h0FEF);
        rows[1] = mk(16'h0033, 16'h0044, 16'h8000, 16'h0555);
        rows[2] = mk(16'h0F00, 16'h00F0, 16'h000F, 16'h0001);
        for (int k = 0; k < 3; k++) send(rows[k]);
        idle(16);
        check("t3_count", cap_val.size(), 12);
        for (int i = 0; i < cap_val.size() && i < 12; i++)
            check("t3_val", cap_val[i], req_m(rows[i/4][(i%4)*AW +: AW]));
        // reset while index 1 is on the output
        clear();
        send(mk(16'h0100, 16'h0200, 16'h0300, 16'h0400));
        in_valid = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            found = out_enable && out_index == 1;
            if (!found) begin
                @(negedge clk);
                #1;
            end
        end
        check("t4_reach_idx1", found, 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
        check("t4_enable", out_enable, 0);
        check("t4_index", out_index, 0);
        check("t4_value", out_value, 0);
        check("t4_last", out_last, 0);
        check("t4_ready", in_ready, 1);
        clear();
        send(mk(16'h0500, 16'h0600, 16'h0700, 16'h0800));
        idle(6);
        check("t4_count", cap_val.size(), 4);
        if (cap_val.size() > 0) begin
            check("t4_first_idx", cap_idx[0], 0);
            check("t4_first_val", cap_val[0], 8'h50);
        end
        // rounding
        clear();
        send(mk(16'h0018, 16'h7FF8, 16'h0000, 16'hFFFF));
        idle(6);
        check("t5_count", cap_val.size(), 4);
        if (cap_val.size() == 4) begin
`ifdef FEEDER_ROUND_EN
            check("t5_round_0018", cap_val[0], 2);
`else
            check("t5_trunc_0018", cap_val[0], 1);
`endif
            check("t5_7ff8", cap_val[1], 255);
            check("t5_neg", cap_val[3], 0);
        end
        // argmax over the emitted stream, ties go to the later index
        clear();
        send(mk(16'h0030, 16'h0090, 16'h0090, 16'h0020));
        idle(6);
        best = -1;
        bi = -1;
        fin = 1'b0;
        for (int i = 0; i < cap_val.size(); i++) begin
            if (cap_idx[i] == 0) best = -1;
            if (cap_val[i] >= best) begin
                best = cap_val[i];
                bi = cap_idx[i];
            end
            if (cap_idx[i] == CA - 1) fin = 1'b1;
        end
        check("t6_argmax_idx", bi, 2);
        check("t6_argmax_valid", fin, 1);
        check("t6_argmax_val", best, 9);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/argmax_feeder.md
Name: argmax_feeder

Overview:
- Upstream stage of the argmax cell.
- Accepts one row of CELL_AMOUNT signed accumulator results from the systolic array in parallel, through a valid/ready handshake.
- Requantizes each lane: arithmetic shift right, then clamp to unsigned DATA_WIDTH.
- Streams the lanes one per cycle as (index, value, enable), which is exactly the input format the argmax cell consumes.
- A one-entry holding buffer lets the next row be accepted while the current row streams, so rows go out back-to-back with no bubble.

Parameters:
- DATA_WIDTH, 8: width of streamed value and index.
- ACC_WIDTH, 16: width of each signed accumulator lane.
- CELL_AMOUNT, 4: lanes per row; must be ≥2 and ≤ 2^DATA_WIDTH.
- SHIFT, 4: requantization right-shift amount; must satisfy 0 ≤ SHIFT < ACC_WIDTH.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  CELL_AMOUNT*ACC_WIDTH  row of signed accumulators; lane i occupies bits [i*ACC_WIDTH +: ACC_WIDTH].
- in_valid  input  1  in_data is valid.
- in_ready  output  1  feeder can accept a row.
- out_index  output  DATA_WIDTH  lane index being emitted.
- out_value  output  DATA_WIDTH  requantized lane value.
- out_enable  output  1  out_index/out_value are valid this cycle.
- out_last  output  1  high together with out_enable when out_index == CELL_AMOUNT-1.

Behaviour:
- Reset (synchronous):
  - out_index, out_value, out_enable, out_last all 0.
  - Holding buffer empty; state IDLE; in_ready reads 1 in the first cycle after reset.
- Requantization, per lane (signed):
  - q = acc >>> SHIFT.
  - If q < 0, value = 0.
  - Else if q > 2^DATA_WIDTH-1, value = 2^DATA_WIDTH-1.
  - Else value = q[DATA_WIDTH-1:0].
- in_ready = !buf_full. This is combinational from registered state and never depends on in_valid.
- A row is accepted on a posedge where in_valid && in_ready. in_data is sampled only on that edge.
- State IDLE (nothing streaming):
  - An accepted row goes directly into the stream register.
  - On the same edge, out_enable←1, out_index←0, out_value←lane 0. The state moves to STREAM.
  - Latency: first output appears in the cycle after the accepting edge.
- State STREAM:
  - Each edge advances out_index by 1 and drives the matching lane value.
  - out_last←1 when the new out_index equals CELL_AMOUNT-1.
- Rows accepted during STREAM go into the holding buffer, making buf_full=1.
- On the edge after index CELL_AMOUNT-1 has been presented:
  - If buf_full: the buffer moves to the stream register, lane 0 is emitted immediately, buf_full←0, and the state stays STREAM (no bubble).
  - Else: out_enable, out_last, out_index and out_value go to 0, and the state returns to IDLE.
- Simultaneous events:
  - Buffer full at the final index with in_valid high: in_ready is 0, so no accept. in_ready rises the cycle after the buffer drains.
  - Buffer empty at the final index with a new accept on the same edge: the new row streams next with no bubble, and the buffer stays empty.
- While out_enable = 0, out_value and out_index are held at 0.
- Reset mid-row: the partial row and the buffer are dropped. Outputs are 0 on the next cycle and no out_last is produced.
- Indices are always emitted 0..CELL_AMOUNT-1 in order, never skipped or repeated, matching the argmax cell's start (index 0) and finish (index CELL_AMOUNT-1) conditions.

Optional Feature:
- Macro: FEEDER_ROUND_EN.
- Defined: round-half-up before the shift.
  - q = (acc + 2^(SHIFT-1)) >>> SHIFT, computed in ACC_WIDTH+1 bits so the add cannot overflow.
  - The rounding constant is 0 when SHIFT = 0.
  - Clamping is unchanged.
- Undefined: plain truncating arithmetic shift.
- Latency and handshake are identical in both builds.

Test Plan:
- Single row, defaults: lanes [0x0100, 0x0FF0, 0xFFFB, 0x7FFF], in_valid for one cycle.
  - Required: starting the cycle after accept, four consecutive cycles of (0,0x10), (1,0xFF), (2,0x00), (3,0xFF).
  - out_last only on index 3; then out_enable=0 and in_ready=1.
- Back-to-back: row A accepted, row B offered on the next cycle.
  - Required: B accepted on that edge, in_ready low from the next cycle until A's index 3 is presented.
  - B's index 0 follows A's index 3 with no gap (8 consecutive enable cycles); then a third row C is accepted.
- Backpressure: hold in_valid high with three rows queued.
  - Required: in_ready never high while the buffer is full; no row lost or duplicated; indices run 0..3 three times.
- Reset mid-row: assert reset while out_index=1.
  - Required: next cycle all outputs 0 and in_ready=1; a fresh row then streams from index 0.
- Rounding: lane value 0x0018.
  - Required: FEEDER_ROUND_EN undefined gives 0x01; defined gives 0x02.
  - With rounding, lane 0x7FF8 gives 0xFF with no wrap.
- Argmax integration: feed the argmax cell from this block with lanes giving values [3,9,9,2].
  - Required: argmax result index 2 (ties resolve to the later index), with its valid bit set.
